// File: rtl/as_mc_controller.sv
// rtl/as_mc_controller.sv - multicycle RV64I sequencing controller with retire counter and illegal-opcode trap
module as_mc_controller #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           opcode_i,
    input  logic                 branch_cond_i,
    input  logic                 mem_ready_i,
    output logic                 pc_wr_o,
    output logic                 ir_wr_o,
    output logic                 adr_src_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 reg_wr_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic [1:0]           result_src_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] instret_o,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_JALRPC = 4'd12,
        S_LUI    = 4'd13,
        S_AUIPC  = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t               state_q;
    state_t               state_d;
    logic                 retire;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            // Set on entry so the flag is already visible in the first TRAP cycle.
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        pc_wr_o      = 1'b0;
        ir_wr_o      = 1'b0;
        adr_src_o    = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        reg_wr_o     = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        result_src_o = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_rd_o     = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_wr_o      = mem_ready_i;
                pc_wr_o      = mem_ready_i;
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG, OP_REG32:  state_d = S_EXECR;
                    OP_IMM, OP_IMM32:  state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adr_src_o = 1'b1;
                mem_rd_o  = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                reg_wr_o     = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                adr_src_o = 1'b1;
                mem_wr_o  = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr_o = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                pc_wr_o     = branch_cond_i;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            // JAL: target already in ALUOut from DECODE; ALU now forms the link value oldPC+4.
            S_JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_wr_o     = 1'b1;
                state_d     = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = S_JALRPC;
            end
            S_JALRPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_wr_o     = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
                state_d     = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                state_d     = S_ALUWB;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset cycles must never write anything, including mid-instruction aborts.
        if (!rst_i) begin
            pc_wr_o      = 1'b0;
            ir_wr_o      = 1'b0;
            adr_src_o    = 1'b0;
            mem_rd_o     = 1'b0;
            mem_wr_o     = 1'b0;
            reg_wr_o     = 1'b0;
            alu_src_a_o  = 2'b00;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 2'b00;
            result_src_o = 2'b00;
        end
    end

    assign illegal_o = illegal_q;
    assign instret_o = instret_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_as_mc_controller.sv
// tb/tb_as_mc_controller.sv - scoreboard bench for the multicycle controller
module tb_as_mc_controller;

    localparam int CW = 6;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
                           S_MWR = 4'd5, S_ER = 4'd6, S_EI = 4'd7, S_WB = 4'd8, S_BR = 4'd9,
                           S_JAL = 4'd10, S_JALR = 4'd11, S_JPC = 4'd12, S_LUI = 4'd13,
                           S_AUI = 4'd14, S_TRAP = 4'd15;

    // strobes {pc_wr, ir_wr, adr_src, mem_rd, mem_wr, reg_wr}
    localparam logic [5:0] ST_0 = 6'b000000, ST_F = 6'b110100, ST_FW = 6'b000100,
                           ST_WB = 6'b000001, ST_RD = 6'b001100, ST_WR = 6'b001010,
                           ST_PC = 6'b100000;
    // selects {a, b, alu_op, result_src}
    localparam logic [7:0] SL_0 = 8'b00_00_00_00, SL_F = 8'b00_10_00_10, SL_D = 8'b01_01_00_00,
                           SL_ER = 8'b10_00_10_00, SL_EI = 8'b10_01_10_00, SL_MA = 8'b10_01_00_00,
                           SL_MWB = 8'b00_00_00_01, SL_BR = 8'b10_00_01_00, SL_J = 8'b01_10_00_00,
                           SL_LUI = 8'b11_01_00_00;

    localparam logic [6:0] OP_ADD = 7'b0110011, OP_LD = 7'b0000011, OP_SW = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_LUI = 7'b0110111, OP_ADDI = 7'b0010011, OP_AUI = 7'b0010111,
                           OP_BAD = 7'b1111111;

    logic          clk;
    logic          rst;
    logic [6:0]    opcode;
    logic          branch_cond;
    logic          mem_ready;
    logic          pc_wr, ir_wr, adr_src, mem_rd, mem_wr, reg_wr, illegal;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
    logic [CW-1:0] instret;
    logic [3:0]    state;

    typedef struct {
        logic [24:0] v;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_cyc  = 0;

    as_mc_controller #(.CNT_WIDTH(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .branch_cond_i(branch_cond),
        .mem_ready_i  (mem_ready),
        .pc_wr_o      (pc_wr),
        .ir_wr_o      (ir_wr),
        .adr_src_o    (adr_src),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .reg_wr_o     (reg_wr),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .result_src_o (result_src),
        .illegal_o    (illegal),
        .instret_o    (instret),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [24:0] act;
            e   = sb.pop_front();
            act = {state, pc_wr, ir_wr, adr_src, mem_rd, mem_wr, reg_wr,
                   alu_src_a, alu_src_b, alu_op, result_src, illegal, instret};
            n_chk++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL cycle%0d outputs {state,strobes,selects,illegal,instret}: actual=%h required=%h",
                         e.n, act, e.v);
            end
        end
    end

    task automatic cyc(input logic r, input logic [6:0] op, input logic bc, input logic rdy,
                       input logic [3:0] st, input logic [5:0] strb, input logic [7:0] sel,
                       input logic ill, input logic [CW-1:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        opcode      = op;
        branch_cond = bc;
        mem_ready   = rdy;
        e.v = {st, strb, sel, ill, cnt};
        e.n = n_cyc;
        n_cyc++;
        sb.push_back(e);
    endtask

    task automatic fd(input logic [6:0] op, input logic [CW-1:0] c);
        cyc(1'b1, op, 1'b0, 1'b1, S_F, ST_F, SL_F, 1'b0, c);
        cyc(1'b1, op, 1'b0, 1'b1, S_D, ST_0, SL_D, 1'b0, c);
    endtask

    initial begin
        rst = 1'b0; opcode = 7'd0; branch_cond = 1'b0; mem_ready = 1'b1;

        repeat (3) cyc(1'b0, 7'd0, 1'b0, 1'b1, S_F, ST_0, SL_0, 1'b0, 0);

        fd(OP_ADD, 0);
        cyc(1'b1, OP_ADD, 1'b0, 1'b1, S_ER, ST_0, SL_ER, 1'b0, 0);
        cyc(1'b1, OP_ADD, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 0);

        fd(OP_LD, 1);
        cyc(1'b1, OP_LD, 1'b0, 1'b1, S_MA, ST_0, SL_MA, 1'b0, 1);
        cyc(1'b1, OP_LD, 1'b0, 1'b0, S_MRD, ST_RD, SL_0, 1'b0, 1);
        cyc(1'b1, OP_LD, 1'b0, 1'b0, S_MRD, ST_RD, SL_0, 1'b0, 1);
        cyc(1'b1, OP_LD, 1'b0, 1'b1, S_MRD, ST_RD, SL_0, 1'b0, 1);
        cyc(1'b1, OP_LD, 1'b0, 1'b1, S_MWB, ST_WB, SL_MWB, 1'b0, 1);

        fd(OP_BR, 2);
        cyc(1'b1, OP_BR, 1'b0, 1'b1, S_BR, ST_0, SL_BR, 1'b0, 2);
        fd(OP_BR, 3);
        cyc(1'b1, OP_BR, 1'b1, 1'b1, S_BR, ST_PC, SL_BR, 1'b0, 3);

        fd(OP_JALR, 4);
        cyc(1'b1, OP_JALR, 1'b0, 1'b1, S_JALR, ST_0, SL_MA, 1'b0, 4);
        cyc(1'b1, OP_JALR, 1'b0, 1'b1, S_JPC, ST_PC, SL_J, 1'b0, 4);
        cyc(1'b1, OP_JALR, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 4);

        cyc(1'b1, OP_SW, 1'b0, 1'b0, S_F, ST_FW, SL_F, 1'b0, 5);
        fd(OP_SW, 5);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, S_MA, ST_0, SL_MA, 1'b0, 5);
        cyc(1'b1, OP_SW, 1'b0, 1'b0, S_MWR, ST_WR, SL_0, 1'b0, 5);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, S_MWR, ST_WR, SL_0, 1'b0, 5);

        fd(OP_JAL, 6);
        cyc(1'b1, OP_JAL, 1'b0, 1'b1, S_JAL, ST_PC, SL_J, 1'b0, 6);
        cyc(1'b1, OP_JAL, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 6);

        fd(OP_LUI, 7);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, S_LUI, ST_0, SL_LUI, 1'b0, 7);
        cyc(1'b1, OP_LUI, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 7);

        fd(OP_ADDI, 8);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, S_EI, ST_0, SL_EI, 1'b0, 8);
        cyc(1'b1, OP_ADDI, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 8);

        fd(OP_AUI, 9);
        cyc(1'b1, OP_AUI, 1'b0, 1'b1, S_AUI, ST_0, SL_D, 1'b0, 9);
        cyc(1'b1, OP_AUI, 1'b0, 1'b1, S_WB, ST_WB, SL_0, 1'b0, 9);

        fd(OP_BAD, 10);
        repeat (10) cyc(1'b1, OP_BAD, 1'b0, 1'b1, S_TRAP, ST_0, SL_0, 1'b1, 10);
        cyc(1'b0, OP_BAD, 1'b0, 1'b1, S_TRAP, ST_0, SL_0, 1'b1, 10);

        // 64 retires on a 6-bit counter: last one wraps to zero
        for (int i = 0; i < 64; i++) begin
            logic [CW-1:0] c;
            logic          t;
            c = CW'(i);
            t = c[0];
            fd(OP_BR, c);
            cyc(1'b1, OP_BR, t, 1'b1, S_BR, {t, 5'b00000}, SL_BR, 1'b0, c);
        end

        fd(OP_SW, 0);
        cyc(1'b1, OP_SW, 1'b0, 1'b1, S_MA, ST_0, SL_MA, 1'b0, 0);
        cyc(1'b1, OP_SW, 1'b0, 1'b0, S_MWR, ST_WR, SL_0, 1'b0, 0);
        cyc(1'b0, OP_SW, 1'b0, 1'b1, S_MWR, ST_0, SL_0, 1'b0, 0);
        cyc(1'b1, OP_SW, 1'b0, 1'b0, S_F, ST_FW, SL_F, 1'b0, 0);

        repeat (2) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/as_mc_controller.md
Name: as_mc_controller

Overview:
- Multicycle sequencing controller for the non-pipelined RV64I core.
- Moore FSM that sequences the shared datapath: register file, immediate generator, a single ALU and a single unified instruction/data memory port. The path runs through fetch, decode, execute, memory and writeback over several cycles per instruction.
- Replaces the single-cycle control path. ALU function select stays in a separate ALU decoder driven by alu_op_o.
- Also keeps a retired-instruction counter and a sticky illegal-opcode trap.

Parameters:
- CNT_WIDTH, 64, width of retired-instruction counter instret_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- opcode_i  in  7  instruction[6:0] from instruction register.
- branch_cond_i  in  1  branch condition evaluated by ALU flag logic (1 = taken).
- mem_ready_i  in  1  memory access complete this cycle.
- pc_wr_o  out  1  PC register write enable.
- ir_wr_o  out  1  instruction register (and oldPC) write enable.
- adr_src_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd_o  out  1  memory read strobe.
- mem_wr_o  out  1  memory write strobe.
- reg_wr_o  out  1  register file write enable.
- alu_src_a_o  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = regA, 11 = zero.
- alu_src_b_o  out  2  ALU B select: 00 = regB, 01 = immediate, 10 = constant 4.
- alu_op_o  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- result_src_o  out  2  00 = ALUOut register, 01 = memory read data, 10 = ALU result.
- illegal_o  out  1  sticky illegal-opcode flag.
- instret_o  out  CNT_WIDTH  retired-instruction count.
- state_o  out  4  current state encoding (debug).

Behaviour:
Reset and output defaults:
- While rst_i = 0 at a clock edge: state <= FETCH, illegal_o <= 0, instret_o <= 0.
- During any cycle with rst_i = 0, all strobes (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr) are forced 0.
- Selects are 0 during reset.
- Reset mid-instruction aborts it with no write.
- Outputs are Moore (state-decoded), except pc_wr_o/ir_wr_o in FETCH and pc_wr_o in BRANCH.
- Unlisted outputs in a state are 0.

States:
- FETCH: adr_src=0, mem_rd=1, a=00, b=10, alu_op=00, result_src=10.
  - ir_wr=pc_wr=mem_ready_i.
  - Stay while mem_ready_i=0; on 1 -> DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 / 0100011 -> MEMADR.
  - 0110011 / 0111011 -> EXECR.
  - 0010011 / 0011011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - 0010111 -> AUIPC.
  - Any other opcode -> TRAP.
- MEMADR: a=10, b=01, add. Load -> MEMRD; store -> MEMWR.
- MEMRD: adr_src=1, mem_rd=1; wait for mem_ready_i, then -> MEMWB.
- MEMWB: result_src=01, reg_wr=1 -> FETCH (retire).
- MEMWR: adr_src=1, mem_wr=1; wait for mem_ready_i, then -> FETCH (retire). mem_wr held high until ready.
- EXECR: a=10, b=00, alu_op=10 -> ALUWB.
- EXECI: a=10, b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_wr=1 -> FETCH (retire).
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_wr=branch_cond_i -> FETCH (retire).
- JAL: a=01, b=10, add, result_src=00 (target), pc_wr=1 -> ALUWB (rd = oldPC+4).
- JALR: a=10, b=01, add -> JALRPC.
- JALRPC: result_src=00, pc_wr=1, a=01, b=10, add -> ALUWB.
- LUI: a=11, b=01, add -> ALUWB.
- AUIPC: a=01, b=01, add -> ALUWB.
- TRAP: illegal_o <= 1, all strobes 0; remain until reset.

Retire counter and cycle counts:
- instret_o increments by 1 on each retire transition. It wraps modulo 2^CNT_WIDTH; no saturation.
- A JAL/JALR retires on ALUWB only; it counts once.
- Cycle counts with zero-wait memory:
  - R/I/LUI/AUIPC: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - JAL: 4.
  - JALR: 5.
- Each memory wait cycle adds 1.

Test Plan:
- Reset: hold rst_i=0 3 cycles with mem_ready_i=1 -> all strobes 0, instret_o=0; first cycle after release: state_o=FETCH, mem_rd_o=1.
- ADD (0110011), mem_ready_i=1 -> states FETCH, DECODE, EXECR, ALUWB; reg_wr_o=1 only in ALUWB; instret_o=1 after 4 cycles.
- Load with mem_ready_i low 2 cycles in MEMRD -> MEMRD lasts 3 cycles with mem_rd_o=1, adr_src_o=1; MEMWB result_src_o=01; total 7 cycles.
- Branch with branch_cond_i=0, then repeat with 1 -> pc_wr_o=0, then 1, in BRANCH; instret increments both times.
- JALR -> JALR, JALRPC (pc_wr_o=1, a=01, b=10), ALUWB (reg_wr_o=1); instret +1.
- Opcode 1111111 -> TRAP; illegal_o=1 and strobes 0 for 10 cycles; rst_i=0 clears illegal_o. Separately, preload instret_o to all-ones via the retire path and retire once -> wraps to 0.
